// File: rtl/dpram_pkg.sv
// Shared types and the byte-lane merge helper for dualport_ram_clr.
// The merge is written at a fixed maximum width; callers size-cast in and out.
package dpram_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } clr_state_t;

    localparam int LANE_MAX_W = 512;
    localparam int LANE_MAX_B = LANE_MAX_W / 8;

    function automatic logic [LANE_MAX_W-1:0] lane_merge(
        input logic [LANE_MAX_W-1:0] old_word,
        input logic [LANE_MAX_W-1:0] new_word,
        input logic [LANE_MAX_B-1:0] byteena
    );
        logic [LANE_MAX_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < LANE_MAX_B; i++) begin
            if (byteena[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dpram_clear_seq.sv
// Clear sequencer: walks every address once after reset or a clear request.
// busy is registered and mirrors the ST_CLEAR state.
module dpram_clear_seq
    import dpram_pkg::*;
#(
    parameter int widthad = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    output logic               busy,
    output logic               clr_we,
    output logic [widthad-1:0] clr_addr
);

    clr_state_t         state, state_nxt;
    logic [widthad-1:0] addr_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
        end else begin
            state    <= state_nxt;
            clr_addr <= addr_nxt;
            busy     <= (state_nxt == ST_CLEAR);
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = clr_addr;
        case (state)
            ST_IDLE: begin
                if (clear) begin
                    state_nxt = ST_CLEAR;
                    addr_nxt  = '0;
                end
            end
            ST_CLEAR: begin
                addr_nxt = clr_addr + widthad'(1);
                if (clr_addr == {widthad{1'b1}}) state_nxt = ST_IDLE;
                // A request during a clear restarts the walk from address 0
                if (clear) begin
                    state_nxt = ST_CLEAR;
                    addr_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
                addr_nxt  = '0;
            end
        endcase
    end

    assign clr_we = (state == ST_CLEAR);

endmodule

// File: rtl/dualport_ram_clr.sv
// True dual-port RAM with byte enables, port-A-wins collisions and a clear sequencer.
// Optional macro DPRAM_CROSS_BYPASS_EN: cross-port reads see the same-cycle write.
module dualport_ram_clr
    import dpram_pkg::*;
#(
    parameter int                 width       = 16,
    parameter int                 widthad     = 10,
    parameter logic [width-1:0]   clear_value = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    output logic                  busy,
    input  logic                  wren_a,
    input  logic [width/8-1:0]    byteena_a,
    input  logic [widthad-1:0]    address_a,
    input  logic [width-1:0]      data_a,
    output logic [width-1:0]      q_a,
    input  logic                  wren_b,
    input  logic [width/8-1:0]    byteena_b,
    input  logic [widthad-1:0]    address_b,
    input  logic [width-1:0]      data_b,
    output logic [width-1:0]      q_b
);

    localparam int NBYTES = width / 8;

    logic [width-1:0]   mem [0:(2**widthad)-1];

    logic               clr_we;
    logic [widthad-1:0] clr_addr;

    logic [NBYTES-1:0]  be_a, be_b;
    logic               same_addr;
    logic [width-1:0]   old_a, old_b;
    logic [width-1:0]   new_a, new_b, final_b;
    logic [width-1:0]   rd_a, rd_b;
    logic               we_a, we_b;
    logic [widthad-1:0] waddr_a;
    logic [width-1:0]   wdata_a;

    dpram_clear_seq #(
        .widthad (widthad)
    ) u_clear_seq (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign be_a      = (wren_a && !busy) ? byteena_a : '0;
    assign be_b      = (wren_b && !busy) ? byteena_b : '0;
    assign same_addr = (address_a == address_b);
    assign old_a     = mem[address_a];
    assign old_b     = mem[address_b];

    // B is merged first so that A overlays it on shared lanes of a shared address
    assign new_b   = width'(lane_merge(LANE_MAX_W'(old_b), LANE_MAX_W'(data_b), LANE_MAX_B'(be_b)));
    assign new_a   = width'(lane_merge(LANE_MAX_W'(same_addr ? new_b : old_a),
                                       LANE_MAX_W'(data_a), LANE_MAX_B'(be_a)));
    assign final_b = same_addr ? new_a : new_b;

`ifdef DPRAM_CROSS_BYPASS_EN
    assign rd_a = new_a;
    assign rd_b = final_b;
`else
    assign rd_a = width'(lane_merge(LANE_MAX_W'(old_a), LANE_MAX_W'(data_a), LANE_MAX_B'(be_a)));
    assign rd_b = new_b;
`endif

    // The sequencer borrows port A's write path while busy
    assign we_a    = busy ? clr_we      : (|be_a);
    assign waddr_a = busy ? clr_addr    : address_a;
    assign wdata_a = busy ? clear_value : new_a;
    assign we_b    = |be_b;

    always_ff @(posedge clock) begin
        if (we_a) mem[waddr_a]   <= wdata_a;
        if (we_b) mem[address_b] <= final_b;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_a <= '0;
            q_b <= '0;
        end else if (busy) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            q_a <= rd_a;
            q_b <= rd_b;
        end
    end

endmodule

// File: tb/tb_dualport_ram_clr.sv
// Bench for dualport_ram_clr (widthad=4, clear_value=16'hA5A5): directed table,
// multi-cycle clear/reset sequences and random traffic against a lane-level model.
module tb_dualport_ram_clr;

    localparam int          DEPTH = 16;
    localparam logic [15:0] CV    = 16'hA5A5;
`ifdef DPRAM_CROSS_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        clear;
    logic        busy;
    logic        wren_a, wren_b;
    logic [1:0]  byteena_a, byteena_b;
    logic [3:0]  address_a, address_b;
    logic [15:0] data_a, data_b;
    logic [15:0] q_a, q_b;

    dualport_ram_clr #(
        .width       (16),
        .widthad     (4),
        .clear_value (CV)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .busy      (busy),
        .wren_a    (wren_a),
        .byteena_a (byteena_a),
        .address_a (address_a),
        .data_a    (data_a),
        .q_a       (q_a),
        .wren_b    (wren_b),
        .byteena_b (byteena_b),
        .address_b (address_b),
        .data_b    (data_b),
        .q_b       (q_b)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: memory contents, remaining clear writes, expected outputs
    logic [15:0] m_mem [DEPTH];
    int          clr_left;
    logic [15:0] e_qa, e_qb;
    logic        e_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_user_access();
        logic [15:0] oa, ob;
        bit          a_en, b_en;
        oa = m_mem[address_a];
        ob = m_mem[address_b];
        e_qa = oa;
        e_qb = ob;
        for (int l = 0; l < 2; l++) begin
            a_en = wren_a && byteena_a[l];
            b_en = wren_b && byteena_b[l];
            if (a_en) m_mem[address_a][8*l +: 8] = data_a[8*l +: 8];
            if (b_en && !(a_en && address_a == address_b))
                m_mem[address_b][8*l +: 8] = data_b[8*l +: 8];
            if (a_en) e_qa[8*l +: 8] = data_a[8*l +: 8];
            if (b_en) e_qb[8*l +: 8] = data_b[8*l +: 8];
        end
        if (BYP) begin
            e_qa = m_mem[address_a];
            e_qb = m_mem[address_b];
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            clr_left = DEPTH;
            m_mem[0] = CV;
            e_qa = '0;
            e_qb = '0;
        end else if (clr_left > 0) begin
            m_mem[DEPTH - clr_left] = CV;
            clr_left--;
            e_qa = '0;
            e_qb = '0;
            if (clear) clr_left = DEPTH;
        end else begin
            model_user_access();
            if (clear) clr_left = DEPTH;
        end
        e_busy = (clr_left > 0);
    endtask

    task automatic cyc();
        @(posedge clock);
        model_edge();
        #1;
        check("q_a", 32'(q_a), 32'(e_qa));
        check("q_b", 32'(q_b), 32'(e_qb));
        check("busy", 32'(busy), 32'(e_busy));
    endtask

    task automatic idle_inputs();
        clear  = 1'b0;
        wren_a = 1'b0;
        wren_b = 1'b0;
        byteena_a = 2'b11;
        byteena_b = 2'b11;
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            n++;
            if (busy === 1'b0) break;
        end
        check(name, 32'(n), 32'(DEPTH));
    endtask

    task automatic read_all(input string name);
        idle_inputs();
        for (int a = 0; a < DEPTH; a++) begin
            address_a = 4'(a);
            address_b = 4'(DEPTH - 1 - a);
            cyc();
            check({name, "_qa"}, 32'(q_a), 32'(CV));
            check({name, "_qb"}, 32'(q_b), 32'(CV));
        end
    endtask

    task automatic async_reset_assert();
        reset    = 1'b1;
        clr_left = DEPTH;
        e_qa     = '0;
        e_qb     = '0;
        e_busy   = 1'b1;
        #1;
        check("async_rst_qa", 32'(q_a), 32'h0);
        check("async_rst_qb", 32'(q_b), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h1);
    endtask

    typedef struct {
        logic        wa;
        logic [1:0]  bea;
        logic [3:0]  aa;
        logic [15:0] da;
        logic        wb;
        logic [1:0]  beb;
        logic [3:0]  ab;
        logic [15:0] db;
        logic [15:0] qa;
        logic [15:0] qb;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;
        clr_left = DEPTH;
        e_qa = '0;
        e_qb = '0;
        e_busy = 1'b1;
        reset = 1'b1;
        idle_inputs();
        address_a = '0;
        address_b = '0;
        data_a = '0;
        data_b = '0;

        vecs[0] = '{1'b1, 2'b01, 4'd3, 16'h1234, 1'b0, 2'b00, 4'd3, 16'h0000,
                    16'hA534, BYP ? 16'hA534 : 16'hA5A5};
        vecs[1] = '{1'b0, 2'b00, 4'd3, 16'h0000, 1'b0, 2'b00, 4'd4, 16'h0000,
                    16'hA534, 16'hA5A5};
        vecs[2] = '{1'b1, 2'b10, 4'd5, 16'h1111, 1'b1, 2'b11, 4'd5, 16'h2222,
                    BYP ? 16'h1122 : 16'h11A5, BYP ? 16'h1122 : 16'h2222};
        vecs[3] = '{1'b0, 2'b00, 4'd5, 16'h0000, 1'b0, 2'b00, 4'd5, 16'h0000,
                    16'h1122, 16'h1122};
        vecs[4] = '{1'b1, 2'b11, 4'd7, 16'hBEEF, 1'b0, 2'b00, 4'd7, 16'h0000,
                    16'hBEEF, BYP ? 16'hBEEF : 16'hA5A5};
        vecs[5] = '{1'b0, 2'b00, 4'd7, 16'h0000, 1'b0, 2'b00, 4'd7, 16'h0000,
                    16'hBEEF, 16'hBEEF};
        vecs[6] = '{1'b1, 2'b00, 4'd7, 16'hFFFF, 1'b0, 2'b00, 4'd7, 16'h0000,
                    16'hBEEF, 16'hBEEF};
        vecs[7] = '{1'b0, 2'b00, 4'd9, 16'h0000, 1'b1, 2'b10, 4'd9, 16'h4321,
                    BYP ? 16'h43A5 : 16'hA5A5, 16'h43A5};
        vecs[8] = '{1'b0, 2'b00, 4'd9, 16'h0000, 1'b0, 2'b00, 4'd7, 16'h0000,
                    16'h43A5, 16'hBEEF};

        // Reset state and the power-on clear
        cyc();
        cyc();
        check("rst_busy", 32'(busy), 32'h1);
        check("rst_qa", 32'(q_a), 32'h0);
        reset = 1'b0;
        count_busy("init_clear_len");
        read_all("init_fill");

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            wren_a    = vecs[i].wa;
            byteena_a = vecs[i].bea;
            address_a = vecs[i].aa;
            data_a    = vecs[i].da;
            wren_b    = vecs[i].wb;
            byteena_b = vecs[i].beb;
            address_b = vecs[i].ab;
            data_b    = vecs[i].db;
            cyc();
            check($sformatf("vec%0d_qa", i), 32'(q_a), 32'(vecs[i].qa));
            check($sformatf("vec%0d_qb", i), 32'(q_b), 32'(vecs[i].qb));
        end

        // Random traffic with frequent same-address collisions and rare clears
        for (int i = 0; i < 400; i++) begin
            address_a = 4'($urandom_range(0, 15));
            address_b = ($urandom_range(0, 2) == 0) ? address_a : 4'($urandom_range(0, 15));
            wren_a    = 1'($urandom_range(0, 1));
            wren_b    = 1'($urandom_range(0, 1));
            byteena_a = 2'($urandom_range(0, 3));
            byteena_b = 2'($urandom_range(0, 3));
            data_a    = 16'($urandom());
            data_b    = 16'($urandom());
            clear     = ($urandom_range(0, 59) == 0);
            cyc();
        end
        idle_inputs();
        for (int i = 0; i < 40 && busy !== 1'b0; i++) cyc();
        check("drain_idle", 32'(busy), 32'h0);

        // Clear restarted at its 8th write; writes during busy are dropped
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check("clr_busy_rise", 32'(busy), 32'h1);
        wren_a = 1'b1;
        wren_b = 1'b1;
        data_a = 16'h0F0F;
        data_b = 16'hF0F0;
        for (int i = 0; i < 7; i++) begin
            address_a = 4'(i);
            address_b = 4'(DEPTH - 1 - i);
            cyc();
        end
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        count_busy("restart_clear_len");
        read_all("restart_fill");

        // Asynchronous reset while idle drops q immediately
        address_a = 4'd2;
        address_b = 4'd3;
        cyc();
        async_reset_assert();
        cyc();
        reset = 1'b0;
        count_busy("idle_rst_clear_len");

        // One-cycle reset in the middle of a clear
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        async_reset_assert();
        cyc();
        reset = 1'b0;
        count_busy("midclr_rst_len");
        read_all("midclr_fill");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
